sample_packer: RTL and testbench
================================

# sample_packer

Downstream of `word_assembler` in the `dco_clk` domain. Collects consecutive valid `sample_word`s into multi-sample beats and presents them on a valid/ready stream through a 2-entry output buffer. Beats that complete while the buffer cannot accept them are dropped. Drops are counted and flagged.

## Interface
Parameters:
- `WORD_W`, default 16: width of one sample word; equals 2*LANES of the assembler.
- `SPB`, default 4: samples per output beat, must be ≥2.
- `DROP_W`, default 16: width of the drop counter.

Ports:
- `dco_clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_word` in WORD_W: sample from `word_assembler`.
- `word_valid` in 1: `sample_word` is valid this cycle.
- `test_mode` in 1: selects ramp source; ignored unless the macro is defined.
- `overflow_clr` in 1: single-cycle clear of `overflow`.
- `m_data` out WORD_W*SPB: packed beat; sample k in `[WORD_W*k +: WORD_W]`, k=0 earliest.
- `m_valid` out 1: output buffer non-empty.
- `m_ready` in 1: consumer accepts the beat when `m_valid && m_ready`.
- `overflow` out 1: sticky, set on any drop.
- `drop_count` out DROP_W: saturating count of dropped beats.

## Operation
- **Pack stage:**
  - Shift register plus index counter `idx`, range 0..SPB-1.
  - On `word_valid`, the sample is written to slot `idx` and `idx` increments.
  - At `idx==SPB-1`, the beat completes and `idx` returns to 0.
  - Cycles with `word_valid` low are ignored. There is no timeout, so a partial beat waits indefinitely.
- **Output buffer:**
  - 2-entry FIFO made of two registers with a read pointer, write pointer and count 0..2.
  - `m_valid = (count != 0)`.
  - `m_data` always shows the head entry.
  - Head and `m_data` stay stable while `m_valid && !m_ready`.
- **Push rule:**
  - A completed beat is pushed if `count < 2` or a pop occurs in the same cycle.
  - Otherwise the beat is dropped:
    - `drop_count` increments, saturating at all-ones.
    - `overflow` is set.
- **Pop:** on `m_valid && m_ready`.
  - Simultaneous push and pop leaves `count` unchanged.
  - With count=1, push+pop makes the new beat the head on the next cycle.
- **overflow:**
  - `overflow_clr` clears it.
  - If a drop and `overflow_clr` occur in the same cycle, set wins.
  - `overflow_clr` never affects `drop_count`.
- **Reset:**
  - An asynchronous assert at any time discards the partial beat and clears the FIFO.
  - No output glitch: after release, packing restarts at slot 0.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `overflow`=0, `drop_count`=0.
  - Internal `idx`=0, `count`=0, ramp=0.
- Latency from the edge sampling the SPB-th `word_valid` to `m_valid`=1 is 1 cycle; the beat is visible after that edge.
- With `word_valid` held high and `m_ready` high, one beat is emitted every SPB cycles with zero loss.
- With `m_ready` low and `word_valid` continuous:
  - Beats 1 and 2 are buffered.
  - Beat 3 and later are dropped.
  - `drop_count` updates on the same edge that completes the dropped beat.
- `m_ready` is used combinationally only in the pop/push decision. Every output is a register.

## Configuration
- **Macro `SAMPLE_PACKER_RAMP_EN`.**
- **Defined:**
  - While `test_mode`=1, each accepted sample is replaced by an internal WORD_W-bit ramp.
  - The ramp starts at 0 after reset, increments on every `word_valid` while `test_mode`=1, and wraps at 2^WORD_W.
  - The ramp holds its value while `test_mode`=0.
  - Switching mode mid-beat applies per sample.
- **Not defined:**
  - No ramp logic is built.
  - `test_mode` is ignored.
  - `sample_word` is always packed.

## Test plan
- **Reset:** `rst_n`=0 → `m_valid`=0, `m_data`=0, `drop_count`=0. After release, feed 0x0001..0x0004 with `m_ready`=1 → one cycle later `m_data`=0x0004_0003_0002_0001, `m_valid`=1 for exactly 1 cycle.
- **Gapped valid:** same 4 samples with `word_valid` low on alternate cycles → identical beat; `m_valid` rises 1 cycle after the 4th valid.
- **Backpressure:**
  - Stimulus: `m_ready`=0 for 16 continuous valid samples.
  - Buffered: beats 1–2.
  - Then: `drop_count`=2, `overflow`=1.
  - After raising `m_ready`: beats pop in order 1 then 2, samples 0x0001..0x0008.
- **Edge cases:**
  - With count=2, push coinciding with pop → accepted, `drop_count` unchanged.
  - `overflow_clr` in the same cycle as a drop → `overflow` remains 1.
- **Mid-beat reset:** 2 samples in, then reset pulse, then 4 samples 0xA0..0xA3 → beat 0x00A3_00A2_00A1_00A0; no stale data.
- **Ramp mode:** with `SAMPLE_PACKER_RAMP_EN`, `test_mode`=1 and 8 valids → beats 0x0003_0002_0001_0000 and 0x0007_0006_0005_0004. Without the macro, the same stimulus packs `sample_word` unchanged.

Source files
------------

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : sample_packer
// Purpose  : Packs consecutive valid sample words into SPB-sample beats and
//            presents them on a valid/ready stream through a 2-entry output
//            buffer. Beats that complete while the buffer is full (and not
//            being popped) are dropped, counted and flagged.
// Ports    : dco_clk       - sole clock
//            rst_n         - asynchronous active-low reset
//            sample_word   - sample from word_assembler (WORD_W)
//            word_valid    - sample_word valid this cycle
//            test_mode     - selects ramp source (only with the macro)
//            overflow_clr  - single-cycle clear of overflow
//            m_data        - packed beat, sample k at [WORD_W*k +: WORD_W]
//            m_valid       - output buffer non-empty
//            m_ready       - consumer accepts beat on m_valid && m_ready
//            overflow      - sticky drop flag
//            drop_count    - saturating count of dropped beats (DROP_W)
// Config   : define SAMPLE_PACKER_RAMP_EN to build the test ramp source.
// Revision : 1.0 - initial release
// ============================================================================
module sample_packer #(
    parameter int WORD_W = 16,
    parameter int SPB    = 4,
    parameter int DROP_W = 16
) (
    input  logic                  dco_clk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     sample_word,
    input  logic                  word_valid,
    input  logic                  test_mode,
    input  logic                  overflow_clr,
    output logic [WORD_W*SPB-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int                 c_IDX_W   = (SPB > 2) ? $clog2(SPB) : 1;
    localparam int                 c_BEAT_W  = WORD_W * SPB;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(SPB - 1);

    // ------------------------------------------------------------------
    // Sample source selection
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] w_sample;

`ifdef SAMPLE_PACKER_RAMP_EN
    logic [WORD_W-1:0] r_ramp;

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp <= '0;
        end else if (word_valid && test_mode) begin
            r_ramp <= r_ramp + 1'b1;
        end
    end

    assign w_sample = test_mode ? r_ramp : sample_word;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_sample           = sample_word;
`endif

    // ------------------------------------------------------------------
    // Pack stage: slots 0..SPB-2 are held in registers; the last sample
    // is taken straight from w_sample on the completing cycle so the beat
    // can be pushed on the same edge.
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]            r_idx;
    logic [SPB-2:0][WORD_W-1:0]    r_slots;
    logic [c_BEAT_W-1:0]           w_beat;
    logic                          w_beat_done;

    assign w_beat_done = word_valid && (r_idx == c_LAST_IDX);
    assign w_beat      = {w_sample, r_slots};

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (word_valid) begin
            r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    for (genvar k = 0; k < SPB - 1; k++) begin : g_slot
        always_ff @(posedge dco_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slots[k] <= '0;
            end else if (word_valid && (r_idx == c_IDX_W'(k))) begin
                r_slots[k] <= w_sample;
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output buffer
    // ------------------------------------------------------------------
    logic [c_BEAT_W-1:0] r_mem [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;
    logic [1:0]          w_count_next;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_BEAT_W-1:0] r_m_data;
    logic [c_BEAT_W-1:0] w_head_next;
    logic                r_m_valid;

    assign w_pop  = (r_count != 2'd0) && m_ready;
    assign w_push = w_beat_done && ((r_count != 2'd2) || w_pop);
    assign w_drop = w_beat_done && !w_push;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Registered copy of the next head entry so m_data is a flop output.
    // When full, a simultaneous push overwrites the slot being popped, so
    // the other slot is the new head either way.
    always_comb begin
        w_head_next = r_m_data;
        if (w_pop) begin
            if (r_count == 2'd2) begin
                w_head_next = r_mem[~r_rptr];
            end else if (w_push) begin
                w_head_next = w_beat;
            end
        end else if ((r_count == 2'd0) && w_push) begin
            w_head_next = w_beat;
        end
    end

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_beat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count   <= w_count_next;
            r_m_data  <= w_head_next;
            r_m_valid <= (w_count_next != 2'd0);
        end
    end

    // ------------------------------------------------------------------
    // Drop accounting: a drop in the same cycle as a clear keeps the flag
    // ------------------------------------------------------------------
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_drop && (r_drop_count != {DROP_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_packer
// Purpose  : Directed self-checking bench for sample_packer (default params).
//            Expected beats are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_packer;

    logic        dco_clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample_word;
    logic        word_valid;
    logic        test_mode;
    logic        overflow_clr;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic [15:0] drop_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 dco_clk = ~dco_clk;

    sample_packer #(
        .WORD_W (16),
        .SPB    (4),
        .DROP_W (16)
    ) u_dut (
        .dco_clk      (dco_clk),
        .rst_n        (rst_n),
        .sample_word  (sample_word),
        .word_valid   (word_valid),
        .test_mode    (test_mode),
        .overflow_clr (overflow_clr),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    task automatic tick();
        @(posedge dco_clk);
        #1;
    endtask

    // One valid sample, sampled on the next edge; valid drops afterwards
    // unless the next call re-asserts it before the following edge.
    task automatic feed(input logic [15:0] v);
        sample_word = v;
        word_valid  = 1'b1;
        tick();
        word_valid  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    localparam logic [63:0] c_B1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] c_B2 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] c_B3 = 64'h000C_000B_000A_0009;

    initial begin
        rst_n        = 1'b0;
        sample_word  = '0;
        word_valid   = 1'b0;
        test_mode    = 1'b0;
        overflow_clr = 1'b0;
        m_ready      = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();

        // ---- back-to-back samples
        for (int i = 1; i <= 4; i++) begin
            sample_word = 16'(i);
            word_valid  = 1'b1;
            tick();
            if (i == 3) chk("b2b_not_yet_valid", 64'(m_valid), 64'd0);
        end
        word_valid = 1'b0;
        chk("b2b_m_valid", 64'(m_valid), 64'd1);
        chk("b2b_m_data", m_data, c_B1);
        tick();
        chk("b2b_one_cycle", 64'(m_valid), 64'd0);

        // ---- gapped samples
        feed(16'h0001); tick();
        feed(16'h0002); tick();
        feed(16'h0003); tick();
        chk("gap_not_yet_valid", 64'(m_valid), 64'd0);
        feed(16'h0004);
        chk("gap_m_valid", 64'(m_valid), 64'd1);
        chk("gap_m_data", m_data, c_B1);
        tick();
        chk("gap_one_cycle", 64'(m_valid), 64'd0);

        // ---- backpressure: 16 continuous samples, 2 buffered, 2 dropped
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            feed(16'(i));
            if (i == 12) chk("bp_drop_same_edge", 64'(drop_count), 64'd1);
        end
        chk("bp_drop_count", 64'(drop_count), 64'd2);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_head_held", m_data, c_B1);
        m_ready = 1'b1;
        tick();
        chk("bp_pop2_valid", 64'(m_valid), 64'd1);
        chk("bp_pop2_data", m_data, c_B2);
        tick();
        chk("bp_empty", 64'(m_valid), 64'd0);

        // ---- full buffer, push coincides with pop
        m_ready = 1'b0;
        for (int i = 1; i <= 11; i++) feed(16'(i));
        m_ready = 1'b1;
        feed(16'h000C);
        m_ready = 1'b0;
        chk("pp_drop_unchanged", 64'(drop_count), 64'd2);
        chk("pp_head", m_data, c_B2);
        m_ready = 1'b1;
        tick();
        chk("pp_new_head", m_data, c_B3);
        tick();
        chk("pp_empty", 64'(m_valid), 64'd0);

        // ---- overflow clear, then clear coinciding with a drop
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_keeps_count", 64'(drop_count), 64'd2);
        m_ready = 1'b0;
        for (int i = 1; i <= 11; i++) feed(16'(i));
        overflow_clr = 1'b1;
        feed(16'h000C);
        overflow_clr = 1'b0;
        chk("clr_vs_drop_overflow", 64'(overflow), 64'd1);
        chk("clr_vs_drop_count", 64'(drop_count), 64'd3);
        m_ready = 1'b1;
        tick();
        tick();
        chk("clr_drained", 64'(m_valid), 64'd0);

        // ---- mid-beat asynchronous reset
        feed(16'h0055);
        feed(16'h0066);
        rst_n = 1'b0;
        #2;
        chk("arst_m_data", m_data, 64'd0);
        chk("arst_drop_count", 64'(drop_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) feed(16'h00A0 + 16'(i));
        chk("mid_rst_valid", 64'(m_valid), 64'd1);
        chk("mid_rst_data", m_data, 64'h00A3_00A2_00A1_00A0);
        tick();
        chk("mid_rst_empty", 64'(m_valid), 64'd0);

        // ---- ramp source (or pass-through when not built)
        test_mode = 1'b1;
        m_ready   = 1'b0;
        for (int i = 0; i < 8; i++) feed(16'h0011 + 16'(i));
        test_mode = 1'b0;
`ifdef SAMPLE_PACKER_RAMP_EN
        chk("ramp_beat1", m_data, 64'h0003_0002_0001_0000);
`else
        chk("ramp_beat1", m_data, 64'h0014_0013_0012_0011);
`endif
        m_ready = 1'b1;
        tick();
`ifdef SAMPLE_PACKER_RAMP_EN
        chk("ramp_beat2", m_data, 64'h0007_0006_0005_0004);
`else
        chk("ramp_beat2", m_data, 64'h0018_0017_0016_0015);
`endif
        tick();
        chk("ramp_empty", 64'(m_valid), 64'd0);
        chk("ramp_no_drop", 64'(drop_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
